// File: rtl/div_repeated_sub_pkg.sv
// Shared definitions for the repeated-subtraction divider: state encodings and default width.
package div_repeated_sub_pkg;

  localparam int STATE_W       = 3;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/div_repeated_sub_if.sv
// Serial operand bus and result/status signals shared by the divider and its requester.
interface div_repeated_sub_if
  import div_repeated_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, busy, done, div_zero
  );

endinterface

// File: rtl/div_repeated_sub_data_path.sv
// Divider datapath: remainder (R), divisor (B) and quotient (Q) registers with subtract/compare.
module div_repeated_sub_data_path
  import div_repeated_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_r,
  input  logic             ld_b,
  input  logic             clr_q,
  input  logic             sub_r,
  input  logic             inc_q,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic             geq,
  output logic             bz
);

  logic [WIDTH-1:0] b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      b <= '0;
      q <= '0;
    end else begin
      if (ld_r)
        r <= data_in;
      else if (sub_r)
        r <= r - b;
      if (ld_b)
        b <= data_in;
      if (clr_q)
        q <= '0;
      else if (inc_q)
        q <= q + WIDTH'(1);
    end
  end

  assign geq = (r >= b);
  assign bz  = (b == '0);

endmodule

// File: rtl/div_repeated_sub.sv
// Unsigned divider by repeated subtraction: serial operand load, FSM controller, datapath sub-module.
//
// state    | meaning
// S_IDLE   | waiting for start; previous results held
// S_LOAD_A | capture dividend into R
// S_LOAD_B | capture divisor into B, clear Q
// S_CALC   | subtract B from R while R >= B
// S_DONE   | results valid; wait for start to drop
module div_repeated_sub
  import div_repeated_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  div_repeated_sub_if.slave bus
);

  state_t           state, state_nxt;
  logic             ld_r, ld_b, clr_q, sub_r, inc_q;
  logic             dz_set, dz_clr;
  logic             geq, bz;
  logic             div_zero;
  logic [WIDTH-1:0] r, q;

  div_repeated_sub_data_path #(.WIDTH(WIDTH)) u_data_path (
    .clk     (clk),
    .rst     (rst),
    .data_in (bus.data_in),
    .ld_r    (ld_r),
    .ld_b    (ld_b),
    .clr_q   (clr_q),
    .sub_r   (sub_r),
    .inc_q   (inc_q),
    .r       (r),
    .q       (q),
    .geq     (geq),
    .bz      (bz)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      div_zero <= 1'b0;
    else if (dz_clr)
      div_zero <= 1'b0;
    else if (dz_set)
      div_zero <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ld_r      = 1'b0;
    ld_b      = 1'b0;
    clr_q     = 1'b0;
    sub_r     = 1'b0;
    inc_q     = 1'b0;
    dz_set    = 1'b0;
    dz_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start)
          state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        ld_r      = 1'b1;
        dz_clr    = 1'b1;
        state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        ld_b      = 1'b1;
        clr_q     = 1'b1;
        state_nxt = S_CALC;
      end
      S_CALC: begin
        // Zero divisor wins over the compare, which would otherwise loop forever.
        if (bz) begin
          dz_set    = 1'b1;
          state_nxt = S_DONE;
        end else if (geq) begin
          sub_r = 1'b1;
          inc_q = 1'b1;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.start)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.quotient  = q;
  assign bus.remainder = r;
  assign bus.busy      = (state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_CALC);
  assign bus.done      = (state == S_DONE);
  assign bus.div_zero  = div_zero;

endmodule
